// File: rtl/reg_bank_arbiter.sv
// Two-requester round-robin arbiter in front of a bank of load-enabled registers.
// Define REG_BANK_ARBITER_R0_ZERO_EN to hardwire word 0 to zero.
module reg_bank_arbiter #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [AW-1:0]    addr0,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata,
  output logic             busy
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic             r_last;
  logic             r_win;
  logic             r_we;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_rdata;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_ack0;
  logic             r_ack1;
  logic             r_busy;

  logic             w_win;
  logic             w_start;
  logic             w_gnt0_d;
  logic             w_gnt1_d;
  logic             w_ack0_d;
  logic             w_ack1_d;
  logic             w_busy_d;
  logic [DEPTH-1:0] w_load_en;
  logic [WIDTH-1:0] w_rd_word;

  // Round-robin: a lone request wins; on a tie the side not served last wins.
  always_comb begin
    if (req0 && req1) begin
      w_win = ~r_last;
    end else begin
      w_win = req1;
    end
  end

  assign w_start = (r_state == S_IDLE) && (req0 || req1);

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_gnt0_d     = 1'b0;
    w_gnt1_d     = 1'b0;
    w_ack0_d     = 1'b0;
    w_ack1_d     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next_state = S_ACCESS;
          w_gnt0_d     = ~w_win;
          w_gnt1_d     = w_win;
        end
      end
      S_ACCESS: begin
        w_next_state = S_RELEASE;
        w_ack0_d     = ~r_win;
        w_ack1_d     = r_win;
      end
      S_RELEASE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    w_busy_d = (w_next_state != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_gnt0  <= w_gnt0_d;
      r_gnt1  <= w_gnt1_d;
      r_ack0  <= w_ack0_d;
      r_ack1  <= w_ack1_d;
      r_busy  <= w_busy_d;
    end
  end

  // Request capture, served-last pointer and read-data register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last  <= 1'b1;
      r_win   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_start) begin
        r_win   <= w_win;
        r_we    <= w_win ? we1 : we0;
        r_addr  <= w_win ? addr1 : addr0;
        r_wdata <= w_win ? wdata1 : wdata0;
      end
      if (r_state == S_ACCESS) begin
        r_last <= r_win;
        if (!r_we) begin
          r_rdata <= w_rd_word;
        end
      end
    end
  end

  always_comb begin
    w_load_en = '0;
    if ((r_state == S_ACCESS) && r_we) begin
      w_load_en[r_addr] = 1'b1;
    end
`ifdef REG_BANK_ARBITER_R0_ZERO_EN
    w_load_en[0] = 1'b0;
`endif
  end

`ifdef REG_BANK_ARBITER_R0_ZERO_EN
  assign w_rd_word = (r_addr == '0) ? '0 : r_mem[r_addr];
`else
  assign w_rd_word = r_mem[r_addr];
`endif

  // NOTE: the bank must read back as zero after reset, so every word is cleared
  // explicitly; this is a register file, not a RAM macro.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst_n) begin
        r_mem[i] <= '0;
      end else if (w_load_en[i]) begin
        r_mem[i] <= r_wdata;
      end
    end
  end

  assign gnt0  = r_gnt0;
  assign gnt1  = r_gnt1;
  assign ack0  = r_ack0;
  assign ack1  = r_ack1;
  assign busy  = r_busy;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter: directed cases plus randomized
// contention checked by a scoreboard against a word-array reference model.
module tb_reg_bank_arbiter;

  localparam int WIDTH = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0, req1, we0, we1;
  logic [AW-1:0]    addr0, addr1;
  logic [WIDTH-1:0] wdata0, wdata1;
  logic             gnt0, gnt1, ack0, ack1, busy;
  logic [WIDTH-1:0] rdata;

  always #5 clk = ~clk;

  reg_bank_arbiter #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word array, served-last pointer, last read value.
  logic [WIDTH-1:0] m_mem [DEPTH];
  logic             m_last;
  logic [WIDTH-1:0] m_rdata;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_last  = 1'b1;
    m_rdata = '0;
  endfunction

  function automatic logic model_winner(input logic r0, input logic r1);
    if (r0 && r1) return ~m_last;
    return r1;
  endfunction

  // Apply one served access; returns the rdata value expected with its ack.
  function automatic logic [WIDTH-1:0] model_access(input logic p, input logic we,
                                                    input logic [AW-1:0] a,
                                                    input logic [WIDTH-1:0] d);
    if (we) begin
`ifdef REG_BANK_ARBITER_R0_ZERO_EN
      if (a != '0) m_mem[a] = d;
`else
      m_mem[a] = d;
`endif
    end else begin
      m_rdata = m_mem[a];
    end
    m_last = p;
    return m_rdata;
  endfunction

  typedef struct packed {
    logic             port;
    logic             we;
    logic [WIDTH-1:0] rdata;
  } exp_t;

  exp_t       sb_q[$];
  logic       mon_en = 1'b0;
  logic [1:0] prev_gnt = 2'b00;

  // Monitor: pops one expectation per ack while the random phase runs.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && (ack0 || ack1)) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_ack", {30'b0, ack1, ack0}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_ack_port", {30'b0, ack1, ack0}, e.port ? 32'd2 : 32'd1);
        check("sb_gnt_before_ack", {30'b0, prev_gnt}, e.port ? 32'd2 : 32'd1);
        check("sb_rdata", {16'b0, rdata}, {16'b0, e.rdata});
      end
    end
    prev_gnt = {gnt1, gnt0};
  end

  task automatic set_cmd(input logic p, input logic req, input logic we,
                         input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    if (p) begin
      req1 = req; we1 = we; addr1 = a; wdata1 = d;
    end else begin
      req0 = req; we0 = we; addr0 = a; wdata0 = d;
    end
  endtask

  // Single-requester transaction with cycle-exact latency checks.
  task automatic do_txn(input logic p, input logic we, input logic [AW-1:0] a,
                        input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] exp_rd;
    logic [31:0]      onehot;
    onehot = p ? 32'd2 : 32'd1;
    @(negedge clk);
    set_cmd(p, 1'b1, we, a, d);
    exp_rd = model_access(p, we, a, d);
    @(negedge clk);
    check("txn_gnt", {30'b0, gnt1, gnt0}, onehot);
    check("txn_ack_early", {30'b0, ack1, ack0}, 32'd0);
    check("txn_busy_access", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check("txn_ack", {30'b0, ack1, ack0}, onehot);
    check("txn_gnt_low", {30'b0, gnt1, gnt0}, 32'd0);
    check("txn_rdata", {16'b0, rdata}, {16'b0, exp_rd});
    set_cmd(p, 1'b0, we, a, d);
    @(negedge clk);
    check("txn_ack_low", {30'b0, ack1, ack0}, 32'd0);
    check("txn_idle", {31'b0, busy}, 32'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         g_port[$];
    int         g_cyc[$];
    logic [1:0] rearm;
    logic [1:0] mask;
    logic [1:0] pending;
    logic       first;
    logic       p;
    logic       t_we   [2];
    logic [AW-1:0]    t_addr [2];
    logic [WIDTH-1:0] t_data [2];

    rst_n = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    // Reset state and empty bank.
    apply_reset();
    check("rst_gnt", {30'b0, gnt1, gnt0}, 32'd0);
    check("rst_ack", {30'b0, ack1, ack0}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_rdata", {16'b0, rdata}, 32'd0);
    for (int i = 0; i < DEPTH; i++) do_txn(i[0], 1'b0, AW'(i), '0);

    // Write then read through the other port, then hold for 10 idle cycles.
    do_txn(1'b0, 1'b1, 3'd5, 16'd1234);
    do_txn(1'b1, 1'b0, 3'd5, '0);
    repeat (10) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) do_txn(1'b1, 1'b0, AW'(i), '0);

    // Contention fairness: both requesters held from reset, re-requesting.
    rst_n = 1'b0;
    set_cmd(1'b0, 1'b1, 1'b0, '0, '0);
    set_cmd(1'b1, 1'b1, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    rearm = 2'b00;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (rearm[0]) req0 = 1'b1;
      if (rearm[1]) req1 = 1'b1;
      rearm = 2'b00;
      if (gnt0) begin g_port.push_back(0); g_cyc.push_back(c); end
      if (gnt1) begin g_port.push_back(1); g_cyc.push_back(c); end
      if (ack0) begin req0 = 1'b0; rearm[0] = 1'b1; end
      if (ack1) begin req1 = 1'b0; rearm[1] = 1'b1; end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(negedge clk);
    check("fair_grant_count", {31'b0, g_port.size() >= 4}, 32'd1);
    for (int i = 0; i < 4 && i < g_port.size(); i++) begin
      check("fair_order", g_port[i], i % 2);
      if (i > 0) check("fair_spacing", g_cyc[i] - g_cyc[i-1], 32'd3);
    end

    // Reset during the ACCESS cycle of a write: no ack, no store.
    apply_reset();
    @(negedge clk);
    set_cmd(1'b0, 1'b1, 1'b1, 3'd2, 16'hBEEF);
    @(negedge clk);
    check("midrst_gnt", {30'b0, gnt1, gnt0}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ack", {30'b0, ack1, ack0}, 32'd0);
    check("midrst_gnt_low", {30'b0, gnt1, gnt0}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    set_cmd(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    do_txn(1'b1, 1'b0, 3'd2, '0);

    // Word 0 write/read (zero when the hardwired-zero option is built in).
    do_txn(1'b0, 1'b1, 3'd0, 16'hFFFF);
    do_txn(1'b1, 1'b0, 3'd0, '0);

    // Randomized rounds with optional contention, checked by the monitor.
    mon_en = 1'b1;
    for (int r = 0; r < 200; r++) begin
      mask = 2'($urandom_range(1, 3));
      for (int k = 0; k < 2; k++) begin
        t_we[k]   = 1'($urandom);
        t_addr[k] = AW'($urandom);
        t_data[k] = WIDTH'($urandom);
      end
      @(negedge clk);
      first = model_winner(mask[0], mask[1]);
      for (int k = 0; k < 2; k++) begin
        p = (k == 0) ? first : ~first;
        if (mask[p]) sb_q.push_back('{port: p, we: t_we[p],
                                      rdata: model_access(p, t_we[p], t_addr[p], t_data[p])});
      end
      for (int k = 0; k < 2; k++)
        if (mask[k]) set_cmd(k[0], 1'b1, t_we[k], t_addr[k], t_data[k]);
      pending = mask;
      for (int c = 0; c < 20 && pending != 2'b00; c++) begin
        @(negedge clk);
        if (ack0 && pending[0]) begin req0 = 1'b0; pending[0] = 1'b0; end
        if (ack1 && pending[1]) begin req1 = 1'b0; pending[1] = 1'b0; end
      end
      check("round_done", {30'b0, pending}, 32'd0);
      req0 = 1'b0; req1 = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
